// File: rtl/rv32i_types_pkg.sv
// Shared RV32I scoreboard types and default sizing constants.
package rv32i_types_pkg;

    localparam int unsigned NUM_REGS_D  = 32;
    localparam int unsigned NUM_WB_D    = 4;
    localparam int unsigned NUM_FU_D    = 4;
    localparam int unsigned TAG_W_D     = 4;
    localparam bit          WAW_STALL_D = 1'b1;
    localparam int unsigned REG_W_D     = $clog2(NUM_REGS_D);

    typedef logic [REG_W_D-1:0] regidx_t;
    typedef logic [TAG_W_D-1:0] rob_tag_t;

    typedef struct packed {
        logic     busy;
        rob_tag_t tag;
    } sb_entry_t;

endpackage

// File: rtl/ooo_sb_entry.sv
// One architectural register's busy/tag state with tag-matched writeback clear.
module ooo_sb_entry #(
    parameter int unsigned IDX    = 1,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned NUM_WB = 4
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*REG_W-1:0] wb_rd,
    input  logic [NUM_WB*TAG_W-1:0] wb_tag,
    input  logic                    set,
    input  logic [TAG_W-1:0]        set_tag,
    input  logic                    flush,
    output logic                    busy,
    output logic                    wb_clear_c
);

    logic             busy_q;
    logic [TAG_W-1:0] tag_q;

    // A writeback only retires the register if it carries the tag of the latest producer.
    always_comb begin
        wb_clear_c = 1'b0;
        for (int unsigned p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p] && (wb_rd[p*REG_W +: REG_W] == REG_W'(IDX)) &&
                (wb_tag[p*TAG_W +: TAG_W] == tag_q)) begin
                wb_clear_c = 1'b1;
            end
        end
        wb_clear_c = wb_clear_c & busy_q;
    end

    // Priority: flush > new producer > writeback; flush keeps the tag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_q <= 1'b0;
            tag_q  <= '0;
        end else if (flush) begin
            busy_q <= 1'b0;
        end else if (set) begin
            busy_q <= 1'b1;
            tag_q  <= set_tag;
        end else if (wb_clear_c) begin
            busy_q <= 1'b0;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/ooo_issue_scoreboard.sv
// Register scoreboard gating in-order issue into out-of-order FUs (RAW/WAW hazards).
module ooo_issue_scoreboard
    import rv32i_types_pkg::*;
#(
    parameter int unsigned NUM_REGS  = NUM_REGS_D,
    parameter int unsigned NUM_WB    = NUM_WB_D,
    parameter int unsigned NUM_FU    = NUM_FU_D,
    parameter int unsigned TAG_W     = TAG_W_D,
    parameter bit          WAW_STALL = WAW_STALL_D
) (
    input  logic                                  CLK,
    input  logic                                  nRST,
    input  logic                                  issue_valid,
    input  logic [$clog2(NUM_REGS)-1:0]           issue_rs1,
    input  logic [$clog2(NUM_REGS)-1:0]           issue_rs2,
    input  logic [$clog2(NUM_REGS)-1:0]           issue_rd,
    input  logic                                  issue_use_rs1,
    input  logic                                  issue_use_rs2,
    input  logic                                  issue_wen,
    input  logic [$clog2(NUM_FU)-1:0]             issue_fu,
    input  logic [TAG_W-1:0]                      issue_tag,
    input  logic [NUM_FU-1:0]                     fu_busy,
    input  logic                                  rob_full,
    input  logic [NUM_WB-1:0]                     wb_valid,
    input  logic [NUM_WB*$clog2(NUM_REGS)-1:0]    wb_rd,
    input  logic [NUM_WB*TAG_W-1:0]               wb_tag,
    input  logic                                  flush,
    output logic                                  issue_accept,
    output logic                                  stall_issue,
    output logic                                  rs1_busy,
    output logic                                  rs2_busy,
    output logic                                  rd_busy,
    output logic [$clog2(NUM_REGS+1)-1:0]         busy_count
);

    localparam int unsigned REG_W = $clog2(NUM_REGS);
    localparam int unsigned CNT_W = $clog2(NUM_REGS + 1);

    logic [NUM_REGS-1:0] busy_vec;
    logic [NUM_REGS-1:0] clear_vec;
    logic [NUM_REGS-1:1] set_vec;
    logic                fu_stall;

    // x0 is hardwired zero: never busy, never cleared.
    assign busy_vec[0]  = 1'b0;
    assign clear_vec[0] = 1'b0;

    for (genvar r = 1; r < int'(NUM_REGS); r++) begin : g_entry
        assign set_vec[r] = issue_accept & issue_wen & (issue_rd == REG_W'(r));

        ooo_sb_entry #(
            .IDX    (r),
            .REG_W  (REG_W),
            .TAG_W  (TAG_W),
            .NUM_WB (NUM_WB)
        ) u_entry (
            .CLK        (CLK),
            .nRST       (nRST),
            .wb_valid   (wb_valid),
            .wb_rd      (wb_rd),
            .wb_tag     (wb_tag),
            .set        (set_vec[r]),
            .set_tag    (issue_tag),
            .flush      (flush),
            .busy       (busy_vec[r]),
            .wb_clear_c (clear_vec[r])
        );
    end

    // Hazard checks see same-cycle writebacks as already retired.
    always_comb begin
        fu_stall = 1'b1;
        if (32'(issue_fu) < NUM_FU) begin
            fu_stall = fu_busy[issue_fu];
        end
        rs1_busy = issue_use_rs1 & (issue_rs1 != '0) & busy_vec[issue_rs1] & ~clear_vec[issue_rs1];
        rs2_busy = issue_use_rs2 & (issue_rs2 != '0) & busy_vec[issue_rs2] & ~clear_vec[issue_rs2];
        rd_busy  = WAW_STALL & issue_wen & (issue_rd != '0) & busy_vec[issue_rd] & ~clear_vec[issue_rd];
        stall_issue  = issue_valid &
                       (rob_full | fu_stall | rs1_busy | rs2_busy | rd_busy | flush);
        issue_accept = issue_valid & ~stall_issue;
    end

    always_comb begin
        busy_count = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            busy_count = busy_count + CNT_W'(busy_vec[i]);
        end
    end

endmodule

// File: tb/tb_ooo_issue_scoreboard.sv
// Scoreboard bench: stall-mode and tag-overwrite-mode instances checked against a behavioural model.
module tb_ooo_issue_scoreboard;

    localparam int NR = 32;
    localparam int NW = 4;
    localparam int NF = 4;
    localparam int TW = 4;
    localparam int RW = 5;
    localparam int CW = 6;

    logic            CLK = 1'b0;
    logic            nRST;
    logic            issue_valid;
    logic [RW-1:0]   issue_rs1, issue_rs2, issue_rd;
    logic            issue_use_rs1, issue_use_rs2, issue_wen;
    logic [1:0]      issue_fu;
    logic [TW-1:0]   issue_tag;
    logic [NF-1:0]   fu_busy;
    logic            rob_full;
    logic [NW-1:0]   wb_valid;
    logic [NW*RW-1:0] wb_rd;
    logic [NW*TW-1:0] wb_tag;
    logic            flush;

    // index 0: WAW_STALL=1, index 1: WAW_STALL=0
    logic [1:0]      accept, stall, rs1b, rs2b, rdb;
    logic [CW-1:0]   cnt [2];

    ooo_issue_scoreboard #(.WAW_STALL(1'b1)) u_dut_s (
        .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2), .issue_wen(issue_wen),
        .issue_fu(issue_fu), .issue_tag(issue_tag), .fu_busy(fu_busy), .rob_full(rob_full),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_tag(wb_tag), .flush(flush),
        .issue_accept(accept[0]), .stall_issue(stall[0]), .rs1_busy(rs1b[0]),
        .rs2_busy(rs2b[0]), .rd_busy(rdb[0]), .busy_count(cnt[0])
    );

    ooo_issue_scoreboard #(.WAW_STALL(1'b0)) u_dut_o (
        .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2), .issue_wen(issue_wen),
        .issue_fu(issue_fu), .issue_tag(issue_tag), .fu_busy(fu_busy), .rob_full(rob_full),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_tag(wb_tag), .flush(flush),
        .issue_accept(accept[1]), .stall_issue(stall[1]), .rs1_busy(rs1b[1]),
        .rs2_busy(rs2b[1]), .rd_busy(rdb[1]), .busy_count(cnt[1])
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string name;
        int    mode;
        int    acc, stl, r1, r2, rd, cnt;
    } exp_t;

    exp_t          exp_q[$];
    logic          m_busy [2][NR];
    logic [TW-1:0] m_tag  [2][NR];
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    function automatic bit m_clear(int m, int r);
        if (r == 0 || !m_busy[m][r]) return 1'b0;
        for (int p = 0; p < NW; p++) begin
            if (wb_valid[p] && wb_rd[p*RW +: RW] == RW'(r) && wb_tag[p*TW +: TW] == m_tag[m][r])
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic exp_t predict(int m, string name);
        exp_t e;
        bit   fub;
        e.name = name;
        e.mode = m;
        e.r1  = int'(issue_use_rs1 && issue_rs1 != 0 && m_busy[m][issue_rs1] && !m_clear(m, int'(issue_rs1)));
        e.r2  = int'(issue_use_rs2 && issue_rs2 != 0 && m_busy[m][issue_rs2] && !m_clear(m, int'(issue_rs2)));
        e.rd  = int'(m == 0 && issue_wen && issue_rd != 0 && m_busy[m][issue_rd] && !m_clear(m, int'(issue_rd)));
        fub   = (int'(issue_fu) >= NF) || fu_busy[issue_fu];
        e.stl = int'(issue_valid && (rob_full || fub || e.r1 != 0 || e.r2 != 0 || e.rd != 0 || flush));
        e.acc = int'(issue_valid && e.stl == 0);
        e.cnt = 0;
        for (int r = 0; r < NR; r++) e.cnt += int'(m_busy[m][r]);
        return e;
    endfunction

    task automatic m_step();
        exp_t e;
        bit   clr [NR];
        for (int m = 0; m < 2; m++) begin
            e = predict(m, "");
            for (int r = 0; r < NR; r++) clr[r] = m_clear(m, r);
            for (int r = 1; r < NR; r++) begin
                if (flush) m_busy[m][r] = 1'b0;
                else if (e.acc != 0 && issue_wen && issue_rd == RW'(r)) begin
                    m_busy[m][r] = 1'b1;
                    m_tag[m][r]  = issue_tag;
                end else if (clr[r]) m_busy[m][r] = 1'b0;
            end
        end
    endtask

    task automatic m_reset();
        for (int m = 0; m < 2; m++)
            for (int r = 0; r < NR; r++) begin
                m_busy[m][r] = 1'b0;
                m_tag[m][r]  = '0;
            end
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        issue_use_rs1 = 0; issue_use_rs2 = 0; issue_wen = 0; issue_fu = 0; issue_tag = 0;
        fu_busy = 0; rob_full = 0; wb_valid = 0; wb_rd = 0; wb_tag = 0; flush = 0;
    endtask

    task automatic iss(input int rs1, input int u1, input int rs2, input int u2,
                       input int rd, input int wen, input int tag, input int fu = 0);
        issue_valid = 1;
        issue_rs1 = RW'(rs1); issue_use_rs1 = u1[0];
        issue_rs2 = RW'(rs2); issue_use_rs2 = u2[0];
        issue_rd  = RW'(rd);  issue_wen = wen[0];
        issue_tag = TW'(tag); issue_fu = 2'(fu);
    endtask

    task automatic wb(input int p, input int rd, input int tag);
        wb_valid[p] = 1'b1;
        wb_rd[p*RW +: RW]  = RW'(rd);
        wb_tag[p*TW +: TW] = TW'(tag);
    endtask

    // Push predictions, sample at the falling edge, then advance the model across the rising edge.
    task automatic cyc(input string name, input int d_stall = -1, input int d_cnt = -1,
                       input int d_ostall = -1, input int d_ocnt = -1);
        exp_t e;
        for (int m = 0; m < 2; m++) exp_q.push_back(predict(m, name));
        @(negedge CLK);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("%s/m%0d/accept", e.name, e.mode), 32'(accept[e.mode]), e.acc);
            chk($sformatf("%s/m%0d/stall",  e.name, e.mode), 32'(stall[e.mode]),  e.stl);
            chk($sformatf("%s/m%0d/rs1b",   e.name, e.mode), 32'(rs1b[e.mode]),   e.r1);
            chk($sformatf("%s/m%0d/rs2b",   e.name, e.mode), 32'(rs2b[e.mode]),   e.r2);
            chk($sformatf("%s/m%0d/rdb",    e.name, e.mode), 32'(rdb[e.mode]),    e.rd);
            chk($sformatf("%s/m%0d/count",  e.name, e.mode), 32'(cnt[e.mode]),    e.cnt);
        end
        if (d_stall  >= 0) chk({name, "/stall_s"}, 32'(stall[0]), d_stall);
        if (d_cnt    >= 0) chk({name, "/count_s"}, 32'(cnt[0]),   d_cnt);
        if (d_ostall >= 0) chk({name, "/stall_o"}, 32'(stall[1]), d_ostall);
        if (d_ocnt   >= 0) chk({name, "/count_o"}, 32'(cnt[1]),   d_ocnt);
        m_step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        m_reset();
        nRST = 1'b0;
        #2;
        chk("rst/count_s", 32'(cnt[0]), 0);
        chk("rst/count_o", 32'(cnt[1]), 0);
        chk("rst/stall_s", 32'(stall[0]), 0);
        chk("rst/accept_s", 32'(accept[0]), 0);
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;

        // RAW hazard and writeback bypass
        idle(); iss(0, 0, 0, 0, 5, 1, 3);       cyc("issue_r5", 0, 0, 0, 0);
        idle(); iss(5, 1, 0, 0, 6, 1, 4);       cyc("raw_r5", 1, 1, 1, 1);
        idle(); iss(5, 1, 0, 0, 6, 1, 4); wb(2, 5, 3); cyc("raw_r5_bypass", 0, 1, 0, 1);

        // stale writeback ignored
        idle(); iss(0, 0, 0, 0, 7, 1, 2);       cyc("issue_r7", 0, 1, 0, 1);
        idle(); wb(0, 7, 9);                    cyc("stale_wb_r7", -1, 2, -1, 2);
        idle();                                 cyc("stale_hold", -1, 2, -1, 2);

        // new producer overrides same-cycle clear; duplicate clears
        idle(); iss(0, 0, 0, 0, 6, 1, 8); wb(1, 6, 4); cyc("wb_and_issue_r6", 0, 2, 0, 2);
        idle(); wb(0, 6, 8); wb(3, 6, 8);       cyc("dual_wb_r6", -1, 2, -1, 2);
        idle();                                 cyc("after_dual", -1, 1, -1, 1);

        // WAW: stall mode vs tag-overwrite mode
        idle(); iss(0, 0, 0, 0, 4, 1, 1);       cyc("issue_r4", 0, 1, 0, 1);
        idle(); iss(0, 0, 0, 0, 4, 1, 5);       cyc("waw_r4", 1, 2, 0, 2);
        idle(); wb(1, 4, 1);                    cyc("wb_r4_old", -1, 2, -1, 2);
        idle();                                 cyc("check_r4", -1, 1, -1, 2);
        idle(); wb(2, 4, 5);                    cyc("wb_r4_new", -1, 1, -1, 2);
        idle();                                 cyc("check_r4b", -1, 1, -1, 1);

        // x0, FU busy, ROB full
        idle(); iss(0, 0, 0, 0, 0, 1, 7);       cyc("issue_x0", 0, 1, 0, 1);
        idle();                                 cyc("x0_count", -1, 1, -1, 1);
        idle(); iss(0, 0, 0, 0, 9, 1, 3, 2); fu_busy = 4'b0100; cyc("fu2_busy", 1, 1, 1, 1);
        idle(); iss(0, 0, 0, 0, 9, 1, 3, 1); fu_busy = 4'b0100; cyc("fu1_free", 0, 1, 0, 1);
        idle(); iss(0, 0, 0, 0, 10, 1, 3); rob_full = 1'b1;     cyc("rob_full", 1, 2, 1, 2);

        // random traffic over a small register window to provoke hazards
        for (int i = 0; i < 300; i++) begin
            idle();
            if ($urandom_range(0, 3) != 0)
                iss($urandom_range(0, 11), $urandom_range(0, 1), $urandom_range(0, 11),
                    $urandom_range(0, 1), $urandom_range(0, 11), $urandom_range(0, 1),
                    $urandom_range(0, 15), $urandom_range(0, 3));
            fu_busy  = 4'($urandom) & 4'($urandom) & 4'($urandom);
            rob_full = ($urandom_range(0, 9) == 0);
            flush    = ($urandom_range(0, 24) == 0);
            for (int p = 0; p < NW; p++) begin
                if ($urandom_range(0, 1) != 0) begin
                    int r;
                    r = $urandom_range(0, 11);
                    wb(p, r, ($urandom_range(0, 2) != 0) ? int'(m_tag[0][r]) : $urandom_range(0, 15));
                end
            end
            cyc("random");
        end

        // flush with ten registers busy
        idle(); flush = 1'b1;                   cyc("flush_pre");
        for (int r = 1; r <= 10; r++) begin
            idle(); iss(0, 0, 0, 0, r, 1, r);   cyc("fill");
        end
        idle(); iss(0, 0, 0, 0, 11, 1, 1); flush = 1'b1; cyc("flush_ten", 1, 10, 1, 10);
        idle();                                 cyc("post_flush", -1, 0, -1, 0);

        // async reset mid-operation
        for (int r = 1; r <= 3; r++) begin
            idle(); iss(0, 0, 0, 0, r, 1, r + 4); cyc("fill3");
        end
        idle();                                 cyc("hold3", -1, 3, -1, 3);
        #2;
        nRST = 1'b0;
        #1;
        chk("async_rst/count_s", 32'(cnt[0]), 0);
        chk("async_rst/count_o", 32'(cnt[1]), 0);
        m_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        idle(); iss(1, 1, 0, 0, 0, 0, 0);       cyc("post_rst_rs1", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ooo_issue_scoreboard.md
OOO_ISSUE_SCOREBOARD -- requirements
Module: ooo_issue_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, meaning architectural register count (x0 hardwired zero).
REQ-002 SHALL have parameter NUM_WB, default 4, meaning number of independent writeback ports.
REQ-003 SHALL have parameter NUM_FU, default 4, meaning number of functional-unit issue channels.
REQ-004 SHALL have parameter TAG_W, default 4, meaning ROB tag width.
REQ-005 SHALL have parameter WAW_STALL, default 1, meaning 1 = stall on busy rd, 0 = tag-overwrite mode.
REQ-006 SHALL have ports:
- CLK  in  1  clock; one clock; reset is asynchronous and active-low.
- nRST  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode presents an instruction.
- issue_rs1, issue_rs2, issue_rd  in  $clog2(NUM_REGS) each  register indices.
- issue_use_rs1, issue_use_rs2, issue_wen  in  1 each  operand/destination valid.
- issue_fu  in  $clog2(NUM_FU)  target FU channel.
- issue_tag  in  TAG_W  ROB tag of the instruction.
- fu_busy  in  NUM_FU  per-channel busy.
- rob_full  in  1  ROB cannot accept.
- wb_valid  in  NUM_WB  per-port writeback valid.
- wb_rd  in  NUM_WB x $clog2(NUM_REGS)  writeback destinations.
- wb_tag  in  NUM_WB x TAG_W  writeback tags.
- flush  in  1  pipeline flush (mispredict/exception).
- issue_accept  out  1  instruction issued this cycle.
- stall_issue  out  1  issue_valid held off.
- rs1_busy, rs2_busy, rd_busy  out  1 each  hazard causes.
- busy_count  out  $clog2(NUM_REGS+1)  registers currently pending.

Function
REQ-007 SHALL keep per-register state {busy, tag}; outputs combinational from state and current inputs; state updates on rising CLK.
REQ-008 SHALL compute wb_clear[r] = any port p with wb_valid[p], wb_rd[p]==r, busy[r], wb_tag[p]==tag[r]; a tag mismatch SHALL be ignored (stale writeback).
REQ-009 SHALL treat a register as available to this cycle's checks when wb_clear[r] is set (same-cycle writeback bypass).
REQ-010 SHALL assert rs1_busy = issue_use_rs1 & rs1!=0 & busy[rs1] & !wb_clear[rs1]; rs2_busy likewise.
REQ-011 SHALL assert rd_busy = WAW_STALL & issue_wen & rd!=0 & busy[rd] & !wb_clear[rd]; with WAW_STALL=0 rd_busy SHALL be 0.
REQ-012 SHALL assert stall_issue = issue_valid & (rob_full | fu_busy[issue_fu] | rs1_busy | rs2_busy | rd_busy | flush).
REQ-013 SHALL assert issue_accept = issue_valid & !stall_issue.
REQ-014 On issue_accept with issue_wen and rd!=0 SHALL set busy[rd]=1, tag[rd]=issue_tag next cycle; this SHALL override a same-cycle wb_clear of rd.
REQ-015 Register 0 SHALL never become busy.
REQ-016 Multiple ports clearing the same register in one cycle SHALL be idempotent.
REQ-017 flush SHALL clear all busy bits next cycle, override issue and writeback in that cycle, and leave tags unchanged.
REQ-018 busy_count SHALL equal popcount of registered busy bits (no lookahead), max NUM_REGS-1.
REQ-019 issue_fu >= NUM_FU SHALL be treated as busy (stall).

Reset
REQ-020 On nRST low, asynchronously: all busy=0, all tag=0; issue_accept=0 when issue_valid=0, stall_issue=0, busy_count=0.
REQ-021 Reset asserted mid-operation SHALL discard all pending state; first cycle after release SHALL accept any issue absent rob_full/fu_busy.

Structure
REQ-022 regidx_t, rob_tag_t and sb_entry_t {busy, tag} SHALL reside in shared package rv32i_types_pkg; module parameters default from package constants.
REQ-023 Per-register clear/set logic SHALL be one sub-module, ooo_sb_entry, instantiated NUM_REGS-1 times via generate.

Verification
REQ-024 Issue rd=5 tag=3; next cycle issue rs1=5 -> stall_issue=1, rs1_busy=1; wb port 2 rd=5 tag=3 -> same cycle issue_accept=1.
REQ-025 busy[7] tag=2; wb rd=7 tag=9 -> busy[7] stays 1, busy_count unchanged.
REQ-026 WAW_STALL=1: rd=4 busy, issue rd=4 -> rd_busy=1; WAW_STALL=0: accept, tag[4]=new tag, old-tag wb ignored, new-tag wb clears.
REQ-027 Ten registers busy, flush with issue_valid -> issue_accept=0; next cycle busy_count=0.
REQ-028 Issue rd=0 accepted -> busy_count stays 0; fu_busy[2]=1, issue_fu=2 -> stall; rob_full=1 -> stall.
REQ-029 nRST pulsed low with 3 registers busy -> busy_count=0 immediately; rs1 previously busy accepted after release.
